// File: rtl/collatz_pkg.sv
// collatz_pkg: shared state encoding and datapath width defaults for collatz_range
// Contents: state_t (controller states), N_BITS_DEF, COUNT_BITS_DEF
package collatz_pkg;
    typedef enum logic [2:0] {IDLE, ARM, LOAD, STEP, WRITE, DONE} state_t;
    localparam int N_BITS_DEF     = 32;
    localparam int COUNT_BITS_DEF = 16;
endpackage

// File: rtl/collatz_iter.sv
// collatz_iter: one Collatz step per clock with a saturating step counter
// Ports: clk, reset_n (async, active-low), load (take n_in, clear steps),
//        n_in (start value), busy (iterating), steps (step count),
//        fin (the step taken this cycle is the final one)
module collatz_iter #(
    parameter int N_BITS     = 32,
    parameter int COUNT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [N_BITS-1:0]     n_in,
    output logic                  busy,
    output logic [COUNT_BITS-1:0] steps,
    output logic                  fin
);
    logic [N_BITS-1:0]     n, nxt_n;
    logic [COUNT_BITS-1:0] nxt_steps;

    // fin looks ahead at the value this step produces, so the controller
    // can leave STEP on the same edge that performs the last step
    always_comb begin
        nxt_n     = n[0] ? (n << 1) + n + N_BITS'(1) : n >> 1;
        nxt_steps = steps + COUNT_BITS'(1);
        fin       = busy && (nxt_n[N_BITS-1:1] == '0 || nxt_steps == '1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n     <= '0;
            steps <= '0;
            busy  <= 1'b0;
        end else if (load) begin
            n     <= n_in;
            steps <= '0;
            busy  <= n_in[N_BITS-1:1] != '0;
        end else if (busy) begin
            n     <= nxt_n;
            steps <= nxt_steps;
            busy  <= !fin;
        end
    end
endmodule

// File: rtl/collatz_range.sv
// collatz_range: computes Collatz step counts for RAM_WORDS consecutive start
// values into an on-chip RAM, then serves them as a read-only table
// Ports: clk, reset_n (async, active-low), go (level, restarts a run),
//        start (base value while go; read address while done),
//        done (RAM holds a complete result set), count (read data, 0 unless done)
module collatz_range
    import collatz_pkg::*;
#(
    parameter int RAM_WORDS     = 256,
    parameter int RAM_ADDR_BITS = 8,
    parameter int N_BITS        = N_BITS_DEF,
    parameter int COUNT_BITS    = COUNT_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  go,
    input  logic [N_BITS-1:0]     start,
    output logic                  done,
    output logic [COUNT_BITS-1:0] count
);
    state_t                   state, nxt;
    logic [N_BITS-1:0]        base, n_in;
    logic [RAM_ADDR_BITS-1:0] index;
    logic [COUNT_BITS-1:0]    steps;
    logic [COUNT_BITS-1:0]    ram [RAM_WORDS];
    logic                     busy, fin, trivial, last;

    assign n_in    = base + N_BITS'(index);
    // 0 and 1 need no steps, so LOAD can skip straight to WRITE
    assign trivial = n_in[N_BITS-1:1] == '0;
    assign last    = index == RAM_ADDR_BITS'(RAM_WORDS - 1);

    collatz_iter #(.N_BITS(N_BITS), .COUNT_BITS(COUNT_BITS)) u_iter (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (state == LOAD),
        .n_in   (n_in),
        .busy   (busy),
        .steps  (steps),
        .fin    (fin)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = IDLE;
            ARM:     nxt = go ? ARM : LOAD;
            LOAD:    nxt = trivial ? WRITE : STEP;
            STEP:    nxt = (fin || !busy) ? WRITE : STEP;
            WRITE:   nxt = last ? DONE : LOAD;
            DONE:    nxt = DONE;
            default: nxt = IDLE;
        endcase
        // go overrides everything, including a final WRITE
        if (go) nxt = ARM;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base  <= '0;
            index <= '0;
            done  <= 1'b0;
            count <= '0;
        end else begin
            if (go) base <= start;
            if (state == ARM) index <= '0;
            else if (state == WRITE && !last) index <= index + RAM_ADDR_BITS'(1);
            done  <= nxt == DONE;
            count <= (state == DONE && !go) ? ram[start[RAM_ADDR_BITS-1:0]] : '0;
        end
    end

    // contents are meaningless until done, so the array carries no reset
    always_ff @(posedge clk) begin
        if (state == WRITE) ram[index] <= steps;
    end
endmodule

// File: tb/tb_collatz_range.sv
// tb_collatz_range: directed, table-driven check of collatz_range runs, reads,
// abort, asynchronous reset and counter saturation
module tb_collatz_range;
    import collatz_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        go = 1'b0, go_s = 1'b0;
    logic [31:0] start = '0, start_s = '0;
    logic        done, done_s;
    logic [15:0] count;
    logic [3:0]  count_s;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    collatz_range dut (
        .clk(clk), .reset_n(reset_n), .go(go), .start(start), .done(done), .count(count)
    );

    collatz_range #(.COUNT_BITS(4)) dut_s (
        .clk(clk), .reset_n(reset_n), .go(go_s), .start(start_s), .done(done_s), .count(count_s)
    );

    typedef struct {
        logic [31:0] base;
        logic [31:0] addr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        chk("done_reached", 32'(done), 1);
    endtask

    task automatic press(input logic [31:0] b);
        @(posedge clk); #1;
        go = 1'b1;
        start = b;
        @(posedge clk); #1;
        chk("go_clears_done", 32'(done), 0);
        chk("go_clears_count", 32'(count), 0);
        repeat (2) @(posedge clk);
        #1 go = 1'b0;
    endtask

    task automatic read(input logic [31:0] addr, input logic [15:0] exp, input string name);
        @(posedge clk); #1;
        start = addr;
        @(posedge clk); #1;
        chk(name, 32'(count), 32'(exp));
    endtask

    task automatic wait_step();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (dut.state == STEP) break;
        end
        chk("reach_step", 32'(dut.state == STEP), 1);
    endtask

    initial begin
        int cur_base;
        vecs[0]  = '{32'd0, 32'd0,     16'd0};
        vecs[1]  = '{32'd0, 32'd1,     16'd0};
        vecs[2]  = '{32'd0, 32'd6,     16'd8};
        vecs[3]  = '{32'd1, 32'd0,     16'd0};
        vecs[4]  = '{32'd1, 32'd1,     16'd1};
        vecs[5]  = '{32'd1, 32'd2,     16'd7};
        vecs[6]  = '{32'd1, 32'd26,    16'd111};
        vecs[7]  = '{32'd1, 32'd255,   16'd8};
        vecs[8]  = '{32'd1, 32'd3,     16'd2};
        vecs[9]  = '{32'd1, 32'd4,     16'd5};
        vecs[10] = '{32'd1, 32'h103,   16'd2};

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("reset_done", 32'(done), 0);
        chk("reset_count", 32'(count), 0);

        cur_base = -1;
        for (int i = 0; i < 11; i++) begin
            if (int'(vecs[i].base) != cur_base) begin
                press(vecs[i].base);
                wait_done(30000);
                cur_base = int'(vecs[i].base);
            end
            read(vecs[i].addr, vecs[i].exp, $sformatf("base%0d_addr%0h", vecs[i].base, vecs[i].addr));
        end

        // one-cycle read latency: count moves only on the edge after the address
        read(32'd3, 16'd2, "lat_addr3");
        start = 32'd4;
        #1 chk("lat_hold_before_edge", 32'(count), 2);
        @(posedge clk); #1;
        chk("lat_addr4", 32'(count), 5);

        // abort a run mid-STEP with a new base
        press(32'd1);
        wait_step();
        go = 1'b1;
        start = 32'd7;
        @(posedge clk); #1;
        chk("abort_state_arm", 32'(dut.state == ARM), 1);
        chk("abort_done_low", 32'(done), 0);
        repeat (2) @(posedge clk);
        #1 go = 1'b0;
        wait_done(30000);
        read(32'd0, 16'd16, "abort_addr0");
        read(32'd1, 16'd3, "abort_addr1");

        // reset between edges while DONE with a nonzero count
        #3 reset_n = 1'b0;
        #1 chk("rst_done_async", 32'(done), 0);
        chk("rst_count_async", 32'(count), 0);
        #2 reset_n = 1'b1;

        // reset between edges during STEP
        press(32'd1);
        wait_step();
        #3 reset_n = 1'b0;
        #1 chk("rst_step_idle_async", 32'(dut.state == IDLE), 1);
        #2 reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk("rst_stays_idle", 32'(dut.state == IDLE), 1);
        chk("rst_stays_not_done", 32'(done), 0);
        chk("rst_index_zero", 32'(dut.index), 0);

        // saturating 4-bit counter
        @(posedge clk); #1;
        go_s = 1'b1;
        start_s = 32'd27;
        repeat (3) @(posedge clk);
        #1 go_s = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            @(posedge clk); #1;
            if (done_s) break;
        end
        chk("sat_done", 32'(done_s), 1);
        start_s = 32'd0;
        @(posedge clk); #1;
        chk("sat_addr0", 32'(count_s), 15);
        start_s = 32'd5;
        @(posedge clk); #1;
        chk("sat_addr5", 32'(count_s), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
